// File: rtl/reg_write_arbiter.sv
// Configuration register file with a round-robin, 4-phase req/ack write arbiter
// shared by the I2C slave port and the parallel-load port.
module reg_write_arbiter #(
    parameter int unsigned REGCOUNT = 24,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i2c_req,
    input  logic [ADDR_W-1:0]          i2c_addr,
    input  logic [DATA_W-1:0]          i2c_data,
    output logic                       i2c_ack,
    input  logic                       par_req,
    input  logic [ADDR_W-1:0]          par_addr,
    input  logic [DATA_W-1:0]          par_data,
    output logic                       par_ack,
    output logic [DATA_W*REGCOUNT-1:0] registers_packed,
    output logic                       err,
    output logic                       err_src,
    input  logic                       err_clr,
    output logic                       busy
);

    localparam int unsigned LOCK_IDX = REGCOUNT - 1;
    localparam logic        SRC_I2C  = 1'b0;
    localparam logic        SRC_PAR  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic              winner_q, winner_d;   // doubles as last_winner
    logic              i2c_ack_q, i2c_ack_d;
    logic              par_ack_q, par_ack_d;
    logic              err_q, err_d;
    logic              err_src_q, err_src_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] regs_q [REGCOUNT];
    logic [DATA_W-1:0] regs_d [REGCOUNT];

    logic              grant;
    logic              pick;
    logic              legal;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Winner selection and legality of the candidate write at the IDLE edge
    always_comb begin
        grant    = (state_q == ST_IDLE) && (i2c_req || par_req);
        pick     = (i2c_req && par_req) ? ~winner_q : par_req;
        sel_addr = (pick == SRC_PAR) ? par_addr : i2c_addr;
        sel_data = (pick == SRC_PAR) ? par_data : i2c_data;
        legal    = (32'(sel_addr) < REGCOUNT) &&
                   !((pick == SRC_PAR) && regs_q[LOCK_IDX][0]);
    end

    // Next-state, register writes, ack pulses and sticky error
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        i2c_ack_d = 1'b0;
        par_ack_d = 1'b0;
        err_d     = err_q;
        err_src_d = err_src_q;
        regs_d    = regs_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d   = ST_ACK;
                    winner_d  = pick;
                    i2c_ack_d = (pick == SRC_I2C);
                    par_ack_d = (pick == SRC_PAR);
                    if (legal) begin
                        regs_d[sel_addr] = sel_data;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!((winner_q == SRC_PAR) ? par_req : i2c_req)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error beats a coincident clear and then owns err_src
        if (grant && !legal) begin
            err_d = 1'b1;
            if (!err_q || err_clr) begin
                err_src_d = pick;
            end
        end else if (err_clr) begin
            err_d     = 1'b0;
            err_src_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            winner_q  <= SRC_PAR;
            i2c_ack_q <= 1'b0;
            par_ack_q <= 1'b0;
            err_q     <= 1'b0;
            err_src_q <= 1'b0;
            busy_q    <= 1'b0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            i2c_ack_q <= i2c_ack_d;
            par_ack_q <= par_ack_d;
            err_q     <= err_d;
            err_src_q <= err_src_d;
            busy_q    <= busy_d;
            regs_q    <= regs_d;
        end
    end

    for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
        assign registers_packed[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign i2c_ack = i2c_ack_q;
    assign par_ack = par_ack_q;
    assign err     = err_q;
    assign err_src = err_src_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a bench-side register/arbiter model pushes
// expected grant order into a queue that an ack monitor pops.
module tb_reg_write_arbiter;

    localparam int unsigned RC = 24;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = RC * DW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i2c_req, par_req, err_clr;
    logic [AW-1:0] i2c_addr, par_addr;
    logic [DW-1:0] i2c_data, par_data;
    logic          i2c_ack, par_ack, err, err_src, busy;
    logic [PW-1:0] registers_packed;

    always #5 clock = ~clock;

    reg_write_arbiter #(.REGCOUNT(RC), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .i2c_req          (i2c_req),
        .i2c_addr         (i2c_addr),
        .i2c_data         (i2c_data),
        .i2c_ack          (i2c_ack),
        .par_req          (par_req),
        .par_addr         (par_addr),
        .par_data         (par_data),
        .par_ack          (par_ack),
        .registers_packed (registers_packed),
        .err              (err),
        .err_src          (err_src),
        .err_clr          (err_clr),
        .busy             (busy)
    );

    int            n_vec = 0;
    int            n_err = 0;
    logic [1:0]    exp_q [$];   // {i2c_ack, par_ack} in expected grant order
    logic [PW-1:0] mdl;
    logic          m_err, m_src, m_last;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && (i2c_ack || par_ack)) begin
            if (exp_q.size() == 0) chk("ack_unexpected", PW'({i2c_ack, par_ack}), '0);
            else                   chk("ack_order", PW'({i2c_ack, par_ack}), PW'(exp_q.pop_front()));
        end
    end

    task automatic m_reset();
        mdl    = '0;
        m_err  = 1'b0;
        m_src  = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic model_write(input logic src, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic clr);
        exp_q.push_back(src ? 2'b01 : 2'b10);
        m_last = src;
        if (32'(a) < RC && !(src && mdl[(RC-1)*DW])) begin
            mdl[32'(a)*DW +: DW] = d;
            if (clr) begin m_err = 1'b0; m_src = 1'b0; end
        end else if (!m_err || clr) begin
            m_err = 1'b1;
            m_src = src;
        end
    endtask

    task automatic set_req(input logic src, input logic r, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        if (src) begin par_req = r; par_addr = a; par_data = d; end
        else     begin i2c_req = r; i2c_addr = a; i2c_data = d; end
    endtask

    task automatic wait_idle(inout int bsy);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!busy) return;
            bsy++;
        end
        chk("idle_timeout", PW'(busy), '0);
    endtask

    task automatic wr(input logic src, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic clr, output int bsy);
        int lat = -1;
        bsy = 0;
        model_write(src, a, d, clr);
        @(posedge clock); #1;
        set_req(src, 1'b1, a, d);
        err_clr = clr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy) bsy++;
            if (src ? par_ack : i2c_ack) begin
                lat = i;
                chk("regs_at_ack", registers_packed, mdl);
                break;
            end
        end
        chk("ack_latency", PW'(lat), PW'(1));
        err_clr = 1'b0;
        set_req(src, 1'b0, a, d);
        wait_idle(bsy);
        chk("regs_after", registers_packed, mdl);
        chk("err_state", PW'({err, err_src}), PW'({m_err, m_src}));
    endtask

    task automatic both(input logic [AW-1:0] ia, input logic [DW-1:0] id,
                        input logic [AW-1:0] pa, input logic [DW-1:0] pd);
        int   acks  = 0;
        int   dummy = 0;
        logic first = ~m_last;
        if (first) begin model_write(1'b1, pa, pd, 1'b0); model_write(1'b0, ia, id, 1'b0); end
        else       begin model_write(1'b0, ia, id, 1'b0); model_write(1'b1, pa, pd, 1'b0); end
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, ia, id);
        set_req(1'b1, 1'b1, pa, pd);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i2c_ack) begin acks++; i2c_req = 1'b0; end
            if (par_ack) begin acks++; par_req = 1'b0; end
            if (acks == 2 && !busy) break;
        end
        chk("both_acks", PW'(acks), PW'(2));
        i2c_req = 1'b0;
        par_req = 1'b0;
        wait_idle(dummy);
        chk("both_regs", registers_packed, mdl);
    endtask

    task automatic fair();
        int   acks  = 0;
        int   dummy = 0;
        logic first = ~m_last;
        logic s;
        for (int k = 0; k < 8; k++) begin
            s = first ^ k[0];
            model_write(s, s ? AW'(11) : AW'(10), s ? 8'hC3 : 8'h3C, 1'b0);
        end
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, AW'(10), 8'h3C);
        set_req(1'b1, 1'b1, AW'(11), 8'hC3);
        for (int i = 0; i < 200 && acks < 8; i++) begin
            @(negedge clock);
            if (i2c_ack) begin acks++; i2c_req = 1'b0; end
            if (par_ack) begin acks++; par_req = 1'b0; end
            if (!busy && acks < 8) begin i2c_req = 1'b1; par_req = 1'b1; end
        end
        i2c_req = 1'b0;
        par_req = 1'b0;
        chk("fair_acks", PW'(acks), PW'(8));
        wait_idle(dummy);
        chk("fair_regs", registers_packed, mdl);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_regs", registers_packed, '0);
        chk("reset_outs", PW'({i2c_ack, par_ack, err, err_src, busy}), '0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int bsy;
        int lat;
        i2c_req = 1'b0; i2c_addr = '0; i2c_data = '0;
        par_req = 1'b0; par_addr = '0; par_data = '0;
        err_clr = 1'b0;
        do_reset();

        // Single I2C write: ack in cycle 1, busy for two cycles
        wr(1'b0, AW'(5), 8'hA7, 1'b0, bsy);
        chk("single_busy", PW'(bsy), PW'(2));
        chk("single_reg5", PW'(registers_packed[47:40]), PW'(8'hA7));

        // Simultaneous same-address requests from reset: I2C then PAR
        do_reset();
        both(AW'(3), 8'h11, AW'(3), 8'h22);
        chk("same_addr_reg3", PW'(registers_packed[31:24]), PW'(8'h22));

        fair();

        // Out-of-range parallel write, then clear
        wr(1'b1, AW'(24), 8'hFF, 1'b0, bsy);
        @(posedge clock); #1 err_clr = 1'b1;
        @(posedge clock); #1 err_clr = 1'b0;
        m_err = 1'b0; m_src = 1'b0;
        chk("err_cleared", PW'({err, err_src}), '0);

        // Lock: parallel rejected, I2C sticky error, clear-vs-error, unlock
        wr(1'b0, AW'(23), 8'h01, 1'b0, bsy);
        wr(1'b1, AW'(0), 8'h55, 1'b0, bsy);
        chk("locked_reg0", PW'(registers_packed[7:0]), '0);
        wr(1'b0, AW'(31), 8'h12, 1'b0, bsy);
        wr(1'b0, AW'(25), 8'h34, 1'b1, bsy);
        wr(1'b0, AW'(23), 8'h00, 1'b0, bsy);
        wr(1'b1, AW'(0), 8'h55, 1'b0, bsy);
        chk("unlocked_reg0", PW'(registers_packed[7:0]), PW'(8'h55));

        // Reset during ACK, then the still-held request is granted again
        @(posedge clock); #1;
        set_req(1'b0, 1'b1, AW'(7), 8'h99);
        exp_q.push_back(2'b10);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i2c_ack) begin lat = i; break; end
        end
        chk("rst_ack_seen", PW'(lat), PW'(1));
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_outs", PW'({i2c_ack, par_ack, err, err_src, busy}), '0);
        chk("rst_mid_regs", registers_packed, '0);
        m_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        model_write(1'b0, AW'(7), 8'h99, 1'b0);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (i2c_ack) begin lat = i; break; end
        end
        chk("rst_regrant_lat", PW'(lat), '0);
        i2c_req = 1'b0;
        bsy = 0;
        wait_idle(bsy);
        chk("rst_regrant_regs", registers_packed, mdl);

        chk("queue_empty", PW'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Owns the 24-entry x 8-bit configuration register file that drives the packed register bus consumed by the IO output block.
- Shares write access between two requesters: the I2C slave write port and the parallel-load port (8-bit data bus plus address).
- Uses a 4-phase req/ack handshake with round-robin arbitration, bounds checking, and a parallel-write lock bit.

Parameters:
- REGCOUNT, 24, number of 8-bit registers.
- DATA_W, 8, register width.
- ADDR_W, 5, requester address width; must satisfy 2**ADDR_W >= REGCOUNT.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i2c_req  input  1  I2C write request; held until ack.
- i2c_addr  input  ADDR_W  I2C target register; stable while i2c_req=1.
- i2c_data  input  DATA_W  I2C write data; stable while i2c_req=1.
- i2c_ack  output  1  one-cycle grant/commit pulse to I2C.
- par_req  input  1  parallel-load write request.
- par_addr  input  ADDR_W  parallel target register.
- par_data  input  DATA_W  parallel write data.
- par_ack  output  1  one-cycle grant/commit pulse to parallel port.
- registers_packed  output  DATA_W*REGCOUNT  register i on bits [8i+7:8i].
- err  output  1  sticky error flag.
- err_src  output  1  source of first error: 0=I2C, 1=parallel.
- err_clr  input  1  synchronous clear of err/err_src.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = 0; state = IDLE.
  - i2c_ack = par_ack = 0; err = err_src = 0.
  - last_winner = PAR, so I2C wins the first tie.
- FSM states: IDLE, ACK, WAIT.
- IDLE:
  - sample i2c_req and par_req at each rising edge.
  - If exactly one is high, it is the winner.
  - If both are high, the winner is the requester that is not last_winner.
  - At that edge: perform the write (if legal), record winner into last_winner, go to ACK.
  - No request: stay in IDLE.
- ACK:
  - the winner's ack is high for exactly this one cycle (registered output); the other ack stays 0.
  - Next edge: go to WAIT unconditionally.
- WAIT:
  - stay until the winner's req is sampled 0, then go to IDLE.
  - The loser's req is ignored until the FSM is back in IDLE.
- Latency and throughput:
  - req high in cycle 0 (state IDLE) -> register updated and visible on registers_packed from cycle 1.
  - ack high in cycle 1.
  - Minimum 3 cycles per write: IDLE, ACK, WAIT with req already dropped.
- Legality (evaluated at the IDLE grant edge):
  - addr >= REGCOUNT: no register changes; ack still pulses; err set.
  - Lock: register 23 bit 0 (LOCK). When 1, parallel writes to any address are rejected (no change, ack pulses, err set). I2C writes are always allowed, including clearing LOCK.
  - A parallel write that sets LOCK is itself accepted.
- err/err_src:
  - err_src is captured only on the 0->1 transition of err; later errors leave it unchanged.
  - err_clr=1 clears both at the next edge.
  - err_clr and a new error on the same edge: the error wins (err=1, err_src = new source).
- Simultaneous same-address requests: both are served sequentially per round-robin; the later write's data remains.
- A requester dropping req before ack is allowed only while it has not been granted; the grant is taken purely from the sampled value.
- Reset asserted mid-transaction (ACK/WAIT): immediate return to reset values; no partial ack.
- Reads are not arbitrated; registers_packed is a direct flop output.

Test Plan:
- Single I2C write (addr=5, data=0xA7):
  - i2c_ack high exactly one cycle after req, in cycle 1.
  - registers_packed[47:40]=0xA7 from cycle 1.
  - busy high for 2 cycles; no other register changes.
- Simultaneous req from reset (I2C addr=3 data=0x11, PAR addr=3 data=0x22):
  - I2C granted first, then PAR.
  - Final reg3=0x22; two ack pulses, I2C's before PAR's.
- Fairness: both reqs held continuously with re-request after each ack -> grants alternate I2C, PAR, I2C, PAR over 8 transactions.
- Out of range: PAR addr=24 data=0xFF -> par_ack pulses, no register changes, err=1, err_src=1. Then err_clr -> err=0.
- Lock sequence:
  - I2C writes reg23=0x01.
  - PAR writes reg0=0x55 -> rejected; reg0 stays 0; err=1, err_src=1.
  - I2C writes reg23=0x00.
  - PAR writes reg0=0x55 -> accepted.
- Reset (reset=0) asserted during ACK -> ack drops immediately, all registers 0, busy=0. After release, a held req is granted normally.
